pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage RISC-V core, replacing the fixed-field, enable-only stage latches. It holds one instruction's payload between two stages using a valid/ready handshake, so stalls come from downstream back-pressure rather than a global enable. A flush input kills the held instruction. An optional second (skid) entry registers the upstream ready path.

## Interface
- DATA_W, 160: payload bits (PC, PC+4, instruction, ALU result, Rs2, Rd, …); held on flush.
- CTRL_W, 8: control bits (RegWrite, MemRW, Branch, Jump, MemtoReg, …); zeroed whenever no valid entry.
- clk_Pipe  in  1  stage clock, rising edge.
- rst_Pipe  in  1  asynchronous, active-high reset.
- valid_in  in  1  upstream presents an instruction.
- ready_out  out  1  stage accepts this cycle; transfer = valid_in & ready_out.
- data_in  in  DATA_W  payload in.
- ctrl_in  in  CTRL_W  control in.
- flush  in  1  discard every held entry and any same-cycle input.
- valid_out  out  1  held instruction valid.
- ready_in  in  1  downstream accepts; transfer = valid_out & ready_in.
- data_out  out  DATA_W  payload of oldest entry.
- ctrl_out  out  CTRL_W  control of oldest entry; 0 when valid_out=0.
- occupancy  out  2  entries held (0..1, or 0..2 with skid).

## Operation
- Reset: valid_out=0, data_out=0, ctrl_out=0, occupancy=0; ready_out=0 while rst_Pipe is high, 1 in the first cycle after release.
- Single-entry mode: ready_out = ~valid_out | ready_in (combinational).
  - In only: load entry, valid_out=1.
  - Out only: valid_out=0, ctrl cleared, data held.
  - In and out together: entry replaced; valid stays 1 (full throughput).
- Flush has priority over everything. Next cycle: valid_out=0, ctrl_out=0, occupancy=0, data unchanged. The same-cycle input is dropped even if it completed the handshake.
- A downstream transfer in a flush cycle still counts as completed: the downstream stage owns that instruction.
- Payload sampled only on an accepted input; ctrl_out never shows stale control while valid_out=0.

## Timing
- Latency: accepted input appears on outputs the following cycle; one instruction per cycle sustained when ready_in=1.
- Skid FSM states and transitions (flush from any state goes to EMPTY):
  - EMPTY: on input, go to ONE.
  - ONE: input and no output, go to TWO (new item into skid). Input and output, stay in ONE (main reloaded). Output only, go to EMPTY.
  - TWO: ready_out=0. On output, go to ONE (skid moves to main, skid ctrl cleared).
- Skid ready_out is a registered ~(state==TWO). Upstream may hold valid_in high with constant payload across a stall; no item is lost or duplicated.
- Reset asserted mid-transfer: all entries discarded asynchronously, with the reset values above.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid FSM. ready_out is registered (no combinational path from ready_in), and occupancy reaches 2.
- Undefined: single entry with combinational ready_out. occupancy[1] is tied to 0.

## Structure
- Package pipe_pkg holds:
  - the state enum PIPE_EMPTY/PIPE_ONE/PIPE_TWO;
  - OCC_W=2;
  - CTRL_RESET constant (all zeros).
- Sub-module pipe_entry: one DATA_W+CTRL_W slot with load, clear-ctrl and async reset. Instanced once, or twice with skid.

## Test plan
- Reset then a stream of 4 items (ctrl=8'hA5, data=1..4) with ready_in=1: outputs 1..4 on consecutive cycles one cycle after input; occupancy stays 1.
- Send item 7, then drop ready_in for 3 cycles while presenting item 8: data_out stays 7. With skid, occupancy=2 and ready_out=0. Release: 7 then 8 delivered, no duplicate.
- Flush while full with valid_in=1: next cycle valid_out=0, ctrl_out=0, occupancy=0, data_out unchanged. The flushed input never appears.
- Out-transfer and flush in the same cycle: downstream receives the item once; stage empty afterwards.
- Assert rst_Pipe asynchronously mid-stall with occupancy=2: all outputs go to reset values immediately. ready_out=0 during reset, 1 one cycle after release.
- Random valid_in/ready_in for 10k cycles against a scoreboard FIFO: in-order, lossless, no duplicates. In skid mode, ready_out never depends combinationally on ready_in.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe_stage_reg inter-stage pipeline register.
package pipe_pkg;

  localparam int unsigned OCC_W      = 2;
  localparam int unsigned CTRL_MAX_W = 256;

  // Control value shown whenever no valid entry is held.
  localparam logic [CTRL_MAX_W-1:0] CTRL_RESET = '0;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_TWO   = 2'd2
  } pipe_state_e;

  function automatic logic [OCC_W-1:0] occ_of_state(pipe_state_e s);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (s)
      PIPE_ONE: occ = 2'd1;
      PIPE_TWO: occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready channel pair seen by one pipe_stage_reg: upstream (in) and downstream (out) sides.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned CTRL_W = 8
);

  logic              valid_in;
  logic              ready_out;
  logic [DATA_W-1:0] data_in;
  logic [CTRL_W-1:0] ctrl_in;

  logic              valid_out;
  logic              ready_in;
  logic [DATA_W-1:0] data_out;
  logic [CTRL_W-1:0] ctrl_out;

  // The stage register drives ready_out and the out side.
  modport master (
    input  valid_in,
    input  data_in,
    input  ctrl_in,
    input  ready_in,
    output ready_out,
    output valid_out,
    output data_out,
    output ctrl_out
  );

  // Surrounding pipeline stages.
  modport slave (
    output valid_in,
    output data_in,
    output ctrl_in,
    output ready_in,
    input  ready_out,
    input  valid_out,
    input  data_out,
    input  ctrl_out
  );

endinterface

// File: rtl/pipe_entry.sv
// One payload+control slot of the stage register; load wins over clear-ctrl, data is never cleared.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk_Pipe,
  input  logic              rst_Pipe,
  input  logic              i_load,
  input  logic              i_clr_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  always_ff @(posedge clk_Pipe or posedge rst_Pipe) begin
    if (rst_Pipe) begin
      r_data <= '0;
      r_ctrl <= CTRL_RESET[CTRL_W-1:0];
    end else if (i_load) begin
      r_data <= i_data;
      r_ctrl <= i_ctrl;
    end else if (i_clr_ctrl) begin
      r_ctrl <= CTRL_RESET[CTRL_W-1:0];
    end
  end

  assign o_data = r_data;
  assign o_ctrl = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready inter-stage pipeline register with flush.
// Define PIPE_STAGE_SKID_EN for the two-entry skid variant with a registered ready_out.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned CTRL_W = 8
) (
  input  logic             clk_Pipe,
  input  logic             rst_Pipe,
  input  logic             flush,
  output logic [OCC_W-1:0] occupancy,
  pipe_stage_reg_if.master bus
);

  logic              w_ready;
  logic              w_valid;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_load0;
  logic              w_clr0;
  logic [DATA_W-1:0] w_data0_d;
  logic [DATA_W-1:0] w_data0_q;
  logic [CTRL_W-1:0] w_ctrl0_d;
  logic [CTRL_W-1:0] w_ctrl0_q;

  assign w_in_xfer  = bus.valid_in & w_ready;
  assign w_out_xfer = w_valid & bus.ready_in;

`ifdef PIPE_STAGE_SKID_EN

  pipe_state_e       r_state;
  logic              r_ready;
  logic              w_load1;
  logic              w_clr1;
  logic              w_sel_skid;
  logic [DATA_W-1:0] w_data1_q;
  logic [CTRL_W-1:0] w_ctrl1_q;

  assign w_ready   = r_ready;
  assign w_valid   = (r_state != PIPE_EMPTY);
  assign occupancy = occ_of_state(r_state);

  // r_ready mirrors "next state is not TWO", so ready_out has no path from ready_in.
  always_ff @(posedge clk_Pipe or posedge rst_Pipe) begin
    if (rst_Pipe) begin
      r_state <= PIPE_EMPTY;
      r_ready <= 1'b0;
    end else if (flush) begin
      r_state <= PIPE_EMPTY;
      r_ready <= 1'b1;
    end else begin
      r_ready <= 1'b1;
      unique case (r_state)
        PIPE_EMPTY: begin
          if (w_in_xfer) r_state <= PIPE_ONE;
        end
        PIPE_ONE: begin
          if (w_in_xfer && !w_out_xfer) begin
            r_state <= PIPE_TWO;
            r_ready <= 1'b0;
          end else if (!w_in_xfer && w_out_xfer) begin
            r_state <= PIPE_EMPTY;
          end
        end
        PIPE_TWO: begin
          if (w_out_xfer) r_state <= PIPE_ONE;
          else            r_ready <= 1'b0;
        end
        default: r_state <= PIPE_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_load0    = 1'b0;
    w_clr0     = 1'b0;
    w_load1    = 1'b0;
    w_clr1     = 1'b0;
    w_sel_skid = 1'b0;
    if (flush) begin
      w_clr0 = 1'b1;
      w_clr1 = 1'b1;
    end else begin
      unique case (r_state)
        PIPE_EMPTY: w_load0 = w_in_xfer;
        PIPE_ONE: begin
          if (w_in_xfer && !w_out_xfer) w_load1 = 1'b1;
          else if (w_in_xfer)           w_load0 = 1'b1;
          else if (w_out_xfer)          w_clr0  = 1'b1;
        end
        PIPE_TWO: begin
          if (w_out_xfer) begin
            w_load0    = 1'b1;
            w_sel_skid = 1'b1;
            w_clr1     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_data0_d = w_sel_skid ? w_data1_q : bus.data_in;
  assign w_ctrl0_d = w_sel_skid ? w_ctrl1_q : bus.ctrl_in;

  pipe_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk_Pipe   (clk_Pipe),
    .rst_Pipe   (rst_Pipe),
    .i_load     (w_load1),
    .i_clr_ctrl (w_clr1),
    .i_data     (bus.data_in),
    .i_ctrl     (bus.ctrl_in),
    .o_data     (w_data1_q),
    .o_ctrl     (w_ctrl1_q)
  );

`else

  logic r_alive;
  logic r_valid;

  // r_alive keeps ready_out low until the first edge after reset release.
  always_ff @(posedge clk_Pipe or posedge rst_Pipe) begin
    if (rst_Pipe) begin
      r_alive <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (flush)           r_valid <= 1'b0;
      else if (w_in_xfer)  r_valid <= 1'b1;
      else if (w_out_xfer) r_valid <= 1'b0;
    end
  end

  assign w_ready   = r_alive & (~r_valid | bus.ready_in);
  assign w_valid   = r_valid;
  assign w_load0   = w_in_xfer & ~flush;
  assign w_clr0    = flush | (w_out_xfer & ~w_in_xfer);
  assign w_data0_d = bus.data_in;
  assign w_ctrl0_d = bus.ctrl_in;
  assign occupancy = {{(OCC_W-1){1'b0}}, r_valid};

`endif

  pipe_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk_Pipe   (clk_Pipe),
    .rst_Pipe   (rst_Pipe),
    .i_load     (w_load0),
    .i_clr_ctrl (w_clr0),
    .i_data     (w_data0_d),
    .i_ctrl     (w_ctrl0_d),
    .o_data     (w_data0_q),
    .o_ctrl     (w_ctrl0_q)
  );

  assign bus.ready_out = w_ready;
  assign bus.valid_out = w_valid;
  assign bus.data_out  = w_data0_q;
  assign bus.ctrl_out  = w_ctrl0_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model plus directed literal checks.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 160;
  localparam int unsigned CW = 8;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] occ;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_stage_reg #(
    .DATA_W (DW),
    .CTRL_W (CW)
  ) dut (
    .clk_Pipe  (clk),
    .rst_Pipe  (rst),
    .flush     (flush),
    .occupancy (occ),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } item_t;

  int unsigned   checks = 0;
  int unsigned   failures = 0;
  item_t         q[$];
  logic [DW-1:0] got[$];
  logic [DW-1:0] last_head = '0;
  bit            alive = 1'b0;
  bit            skid_rdy = 1'b0;
  bit            last_in_x = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    if (!alive) return 1'b0;
    if (SKID) return skid_rdy;
    return (q.size() == 0) || (bus.ready_in == 1'b1);
  endfunction

  // Outputs must reflect the model's held queue: head item, or last head's data when empty.
  task automatic cmp();
    chk("valid_out", bus.valid_out, q.size() > 0);
    chk("ready_out", bus.ready_out, m_ready());
    chk("occupancy", occ, q.size());
    if (q.size() > 0) begin
      chk("ctrl_out", bus.ctrl_out, q[0].c);
      chk("data_out", bus.data_out, q[0].d);
    end else begin
      chk("ctrl_out", bus.ctrl_out, '0);
      chk("data_out", bus.data_out, last_head);
    end
  endtask

  task automatic model_edge();
    bit    in_x;
    bit    out_x;
    item_t it;
    if (rst) begin
      q.delete();
      last_head = '0;
      alive     = 1'b0;
      skid_rdy  = 1'b0;
      last_in_x = 1'b0;
      return;
    end
    in_x      = (bus.valid_in == 1'b1) && m_ready();
    out_x     = (q.size() > 0) && (bus.ready_in == 1'b1);
    last_in_x = in_x;
    if (out_x) begin
      it = q.pop_front();
      got.push_back(it.d);
    end
    if (flush) begin
      q.delete();
    end else if (in_x) begin
      it.d = bus.data_in;
      it.c = bus.ctrl_in;
      q.push_back(it);
    end
    if (q.size() > 0) last_head = q[0].d;
    skid_rdy = (q.size() < 2);
    alive    = 1'b1;
  endtask

  task automatic step(input bit v, input bit r, input bit f, input logic [DW-1:0] d,
                      input logic [CW-1:0] c);
    @(negedge clk);
    bus.valid_in = v;
    bus.ready_in = r;
    flush        = f;
    bus.data_in  = d;
    bus.ctrl_in  = c;
    #1;
    cmp();
    model_edge();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    flush        = 1'b0;
    bus.data_in  = '0;
    bus.ctrl_in  = '0;
    model_edge();
    repeat (2) @(negedge clk);
    #1;
    cmp();
    chk("rst_ready_low", bus.ready_out, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    cmp();
    model_edge();
    @(posedge clk);
    #1;
    chk("ready_after_rst", bus.ready_out, 1);
    chk("valid_after_rst", bus.valid_out, 0);
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    bit            v8;
    bit            pv;
    logic [DW-1:0] pd;
    logic [CW-1:0] pc;
    bit            rdy0;

    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    bus.data_in  = '0;
    bus.ctrl_in  = '0;
    do_reset();

    // Stream 1..4 at full throughput.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 1'b0, DW'(i), 8'hA5);
      @(posedge clk);
      #1;
      chk("stream_data", bus.data_out, i);
      chk("stream_ctrl", bus.ctrl_out, 8'hA5);
      chk("stream_occ", occ, 1);
    end
    step(1'b0, 1'b1, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    chk("drain_valid", bus.valid_out, 0);
    chk("drain_ctrl", bus.ctrl_out, 0);
    chk("drain_data_held", bus.data_out, 4);

    // Stall with item 8 waiting upstream.
    got.delete();
    step(1'b1, 1'b1, 1'b0, 7, 8'hA5);
    @(posedge clk);
    #1;
    chk("stall_first", bus.data_out, 7);
    v8 = 1'b1;
    repeat (3) begin
      step(v8, 1'b0, 1'b0, 8, 8'hA5);
      if (last_in_x) v8 = 1'b0;
      @(posedge clk);
      #1;
      chk("stall_data", bus.data_out, 7);
      chk("stall_ready", bus.ready_out, 0);
      chk("stall_occ", occ, SKID ? 2 : 1);
    end
    step(v8, 1'b1, 1'b0, 8, 8'hA5);
    @(posedge clk);
    #1;
    chk("release_data", bus.data_out, 8);
    chk("release_valid", bus.valid_out, 1);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    chk("release_empty", bus.valid_out, 0);
    chk("release_count", got.size(), 2);
    chk("release_first", got[0], 7);
    chk("release_second", got[1], 8);

    // Flush while full with a same-cycle input.
    step(1'b1, 1'b1, 1'b0, 9, 8'h5A);
    step(1'b1, 1'b0, 1'b1, 10, 8'h5A);
    @(posedge clk);
    #1;
    chk("flush_valid", bus.valid_out, 0);
    chk("flush_ctrl", bus.ctrl_out, 0);
    chk("flush_occ", occ, 0);
    chk("flush_data", bus.data_out, 9);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    chk("flush_dropped", bus.valid_out, 0);

    // Downstream transfer in the flush cycle.
    got.delete();
    step(1'b1, 1'b1, 1'b0, 11, 8'h3C);
    step(1'b0, 1'b1, 1'b1, '0, '0);
    @(posedge clk);
    #1;
    chk("outflush_valid", bus.valid_out, 0);
    chk("outflush_occ", occ, 0);
    chk("outflush_count", got.size(), 1);
    chk("outflush_item", got[0], 11);

    // Asynchronous reset in the middle of a stall.
    step(1'b1, 1'b1, 1'b0, 20, 8'h0F);
    step(1'b1, 1'b0, 1'b0, 21, 8'h0F);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    chk("prerst_occ", occ, SKID ? 2 : 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", bus.valid_out, 0);
    chk("arst_data", bus.data_out, 0);
    chk("arst_ctrl", bus.ctrl_out, 0);
    chk("arst_occ", occ, 0);
    chk("arst_ready", bus.ready_out, 0);
    do_reset();

    // Random traffic; upstream holds an item until it is accepted or flushed.
    pv = 1'b0;
    pd = '0;
    pc = '0;
    for (int n = 0; n < 10000; n++) begin
      bit f;
      bit r;
      f = ($urandom_range(0, 49) == 0);
      r = ($urandom_range(0, 99) < 65);
      if (!pv && ($urandom_range(0, 99) < 70)) begin
        pv = 1'b1;
        pd = rand_data();
        pc = CW'($urandom);
      end
      step(pv, r, f, pd, pc);
`ifdef PIPE_STAGE_SKID_EN
      if ((n % 16) == 0) begin
        rdy0 = bus.ready_out;
        bus.ready_in = ~r;
        #1;
        chk("ready_no_comb_path", bus.ready_out, rdy0);
        bus.ready_in = r;
      end
`else
      rdy0 = 1'b0;
`endif
      if (last_in_x || f) pv = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
